// File: rtl/pattern_frame_ctrl_pkg.sv
// Shared constants for the pattern frame sequencer: FSM state encoding,
// counter width and default line/blanking counts.
package pattern_frame_ctrl_pkg;

  // Width of the line index and of the blanking timer.
  localparam int CNT_W = 12;

  // FSM state encoding, kept as plain constants for legacy tools.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HBLANK = 2'd2;
  localparam logic [1:0] ST_VBLANK = 2'd3;

  // Default frame geometry.
  localparam int DEF_LINES_NORMAL = 720;
  localparam int DEF_LINES_TEST   = 16;
  localparam int DEF_HBLANK_CYC   = 32;
  localparam int DEF_VBLANK_CYC   = 256;

endpackage

// File: rtl/pattern_frame_ctrl_if.sv
// Control/pixel-counter bundle of the pattern frame sequencer.
// frame_cnt exists only when PATTERN_FRAME_CNT_EN is defined.
interface pattern_frame_ctrl_if;
  import pattern_frame_ctrl_pkg::*;

  logic             start;
  logic             stop;
  logic             test;
  logic             end_line;
  logic             pix_enb;
  logic             pix_test;
  logic [CNT_W-1:0] line_idx;
  logic             hblank;
  logic             vblank;
  logic             frame_start;
  logic             frame_done;
  logic             busy;
`ifdef PATTERN_FRAME_CNT_EN
  logic [15:0]      frame_cnt;
`endif

  // Environment side: top-level control plus the pixel counter flag.
  modport master (
    output start, stop, test, end_line,
    input  pix_enb, pix_test, line_idx, hblank, vblank,
           frame_start, frame_done, busy
`ifdef PATTERN_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

  // Sequencer side.
  modport slave (
    input  start, stop, test, end_line,
    output pix_enb, pix_test, line_idx, hblank, vblank,
           frame_start, frame_done, busy
`ifdef PATTERN_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

endinterface

// File: rtl/pattern_blank_timer.sv
// Blanking timer: 12-bit down-counter loaded on every state entry.
// done is high while the count is zero, so a load of N-1 yields N cycles.
module pattern_blank_timer
  import pattern_frame_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise count down and hold at zero.
  always_comb begin
    // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/pattern_frame_ctrl.sv
// Frame sequencer for the pattern generator: drives the pixel counter,
// counts active lines, inserts horizontal/vertical blanking and strobes
// frame_start/frame_done. Optional PATTERN_FRAME_CNT_EN adds frame_cnt.
module pattern_frame_ctrl
  import pattern_frame_ctrl_pkg::*;
#(
  parameter int LINES_NORMAL = DEF_LINES_NORMAL,
  parameter int LINES_TEST   = DEF_LINES_TEST,
  parameter int HBLANK_CYC   = DEF_HBLANK_CYC,
  parameter int VBLANK_CYC   = DEF_VBLANK_CYC
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  pattern_frame_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_NORMAL = CNT_W'(LINES_NORMAL - 1);
  localparam logic [CNT_W-1:0] LAST_TEST   = CNT_W'(LINES_TEST - 1);
  localparam logic [CNT_W-1:0] HB_LOAD     = CNT_W'(HBLANK_CYC - 1);
  localparam logic [CNT_W-1:0] VB_LOAD     = CNT_W'(VBLANK_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] line_idx_q, line_idx_d;
  logic             pix_test_q, pix_test_d;
  logic             stop_pend_q, stop_pend_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val;
  logic [CNT_W-1:0] last_line;
`ifdef PATTERN_FRAME_CNT_EN
  logic [15:0]      frame_cnt_q, frame_cnt_d;
`endif

  pattern_blank_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Mode is frozen for the frame, so the last line follows pix_test_q.
  assign last_line = pix_test_q ? LAST_TEST : LAST_NORMAL;

  // FSM next state, line index, mode freeze, stop request and strobes.
  always_comb begin
    state_d       = state_q;
    line_idx_d    = line_idx_q;
    pix_test_d    = pix_test_q;
    stop_pend_d   = stop_pend_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    tmr_load      = 1'b0;
    tmr_val       = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d       = ST_ACTIVE;
          pix_test_d    = bus.test;
          line_idx_d    = '0;
          stop_pend_d   = 1'b0;
          frame_start_d = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (bus.end_line) begin
          if (line_idx_q == last_line) begin
            state_d      = ST_VBLANK;
            frame_done_d = 1'b1;
          end else begin
            state_d = ST_HBLANK;
          end
        end
      end
      ST_HBLANK: begin
        if (tmr_done) begin
          state_d    = ST_ACTIVE;
          line_idx_d = line_idx_q + CNT_W'(1);
        end
      end
      ST_VBLANK: begin
        if (tmr_done) begin
          line_idx_d = '0;
          if (stop_pend_q || !bus.start) begin
            state_d = ST_IDLE;
          end else begin
            state_d       = ST_ACTIVE;
            pix_test_d    = bus.test;
            frame_start_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A stop seen while running is remembered until the frame boundary.
    if (state_q != ST_IDLE && bus.stop) stop_pend_d = 1'b1;

    // Restart the blanking timer on every state entry.
    if (state_d != state_q) begin
      tmr_load = 1'b1;
      if (state_d == ST_HBLANK)      tmr_val = HB_LOAD;
      else if (state_d == ST_VBLANK) tmr_val = VB_LOAD;
    end
  end

`ifdef PATTERN_FRAME_CNT_EN
  // Completed-frame counter, cleared when a new run starts.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q == ST_IDLE && bus.start) frame_cnt_d = '0;
    else if (frame_done_q)               frame_cnt_d = frame_cnt_q + 16'd1;
  end
`endif

  // State and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      line_idx_q    <= '0;
      pix_test_q    <= 1'b0;
      stop_pend_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
`ifdef PATTERN_FRAME_CNT_EN
      frame_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      line_idx_q    <= line_idx_d;
      pix_test_q    <= pix_test_d;
      stop_pend_q   <= stop_pend_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
`ifdef PATTERN_FRAME_CNT_EN
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  assign bus.pix_enb     = (state_q == ST_ACTIVE);
  assign bus.hblank      = (state_q == ST_HBLANK);
  assign bus.vblank      = (state_q == ST_VBLANK);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.pix_test    = pix_test_q;
  assign bus.line_idx    = line_idx_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
`ifdef PATTERN_FRAME_CNT_EN
  assign bus.frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_pattern_frame_ctrl.sv
// Self-checking bench for pattern_frame_ctrl with a small frame geometry
// and a behavioural pixel counter that ends a line after 8 enabled cycles.
module tb_pattern_frame_ctrl;
  import pattern_frame_ctrl_pkg::*;

  localparam int LN  = 3;
  localparam int LT  = 2;
  localparam int HB  = 3;
  localparam int VB  = 5;
  localparam int PIX = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #8 clk = ~clk;

  pattern_frame_ctrl_if bus_if();

  pattern_frame_ctrl #(
    .LINES_NORMAL (LN),
    .LINES_TEST   (LT),
    .HBLANK_CYC   (HB),
    .VBLANK_CYC   (VB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Behavioural pixel counter: end_line in the 8th enabled cycle.
  logic [3:0] pix_cnt;
  logic       inj_end;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    pix_cnt <= '0;
    else if (!bus_if.pix_enb)      pix_cnt <= '0;
    else if (pix_cnt == 4'(PIX-1)) pix_cnt <= '0;
    else                           pix_cnt <= pix_cnt + 4'd1;
  end
  assign bus_if.end_line = (bus_if.pix_enb && pix_cnt == 4'(PIX-1)) | inj_end;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: frame position as a cycle offset within the frame.
  bit m_run, m_test, m_stop;
  int m_t, m_lines, m_fcnt;

  function automatic int act_len(input int l);
    return l * PIX + (l - 1) * HB;
  endfunction

  function automatic bit model_active();
    return m_run && (m_t < act_len(m_lines)) && ((m_t % (PIX + HB)) < PIX);
  endfunction

  task automatic model_reset();
    m_run = 0; m_test = 0; m_stop = 0; m_t = 0; m_lines = LN; m_fcnt = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit t);
    bit was_run;
    int al;
    was_run = m_run;
    if (!m_run) begin
      if (s) begin
        m_run = 1; m_t = 0; m_test = t; m_lines = t ? LT : LN; m_stop = 0; m_fcnt = 0;
      end
    end else begin
      al = act_len(m_lines);
      if (m_t == al) m_fcnt = (m_fcnt + 1) & 16'hFFFF;
      if (m_t == al + VB - 1) begin
        m_t = 0;
        if (m_stop || !s) begin
          m_run = 0;
        end else begin
          m_test = t; m_lines = t ? LT : LN;
        end
      end else begin
        m_t++;
      end
    end
    if (was_run) m_stop = m_stop | p;
  endtask

  // Compare every output against the model.
  task automatic compare_all();
    logic e_enb, e_hb, e_vb, e_fs, e_fd;
    int   e_line, al;
    e_enb = 0; e_hb = 0; e_vb = 0; e_fs = 0; e_fd = 0; e_line = 0;
    if (m_run) begin
      al = act_len(m_lines);
      if (m_t < al) begin
        e_line = m_t / (PIX + HB);
        e_enb  = (m_t % (PIX + HB)) < PIX;
        e_hb   = !e_enb;
      end else begin
        e_vb   = 1;
        e_line = m_lines - 1;
      end
      e_fs = (m_t == 0);
      e_fd = (m_t == al);
    end
    check("busy",        32'(bus_if.busy),        32'(m_run));
    check("pix_enb",     32'(bus_if.pix_enb),     32'(e_enb));
    check("hblank",      32'(bus_if.hblank),      32'(e_hb));
    check("vblank",      32'(bus_if.vblank),      32'(e_vb));
    check("line_idx",    32'(bus_if.line_idx),    32'(e_line));
    check("frame_start", 32'(bus_if.frame_start), 32'(e_fs));
    check("frame_done",  32'(bus_if.frame_done),  32'(e_fd));
    check("pix_test",    32'(bus_if.pix_test),    32'(m_test));
`ifdef PATTERN_FRAME_CNT_EN
    check("frame_cnt",   32'(bus_if.frame_cnt),   32'(m_fcnt));
`endif
  endtask

  // One clock: drive at negedge, update model at posedge, check at negedge.
  task automatic cycle(input bit s, input bit p, input bit t, input bit inj);
    bus_if.start = s; bus_if.stop = p; bus_if.test = t; inj_end = inj;
    @(posedge clk);
    model_step(s, p, t);
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    int          cyc;
    logic        enb, hb, vb;
    logic [11:0] line;
    logic        fs, fd, busy;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int ti, fs_a, fs_b, fd_a, fd_b, n_fs, max_line;
    bit s, inj;

    bus_if.start = 0; bus_if.stop = 0; bus_if.test = 0; inj_end = 0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Single frame, normal mode: expected waveform points.
    tbl[0]  = '{0,  1,0,0, 12'd0, 1,0,1};
    tbl[1]  = '{7,  1,0,0, 12'd0, 0,0,1};
    tbl[2]  = '{8,  0,1,0, 12'd0, 0,0,1};
    tbl[3]  = '{10, 0,1,0, 12'd0, 0,0,1};
    tbl[4]  = '{11, 1,0,0, 12'd1, 0,0,1};
    tbl[5]  = '{19, 0,1,0, 12'd1, 0,0,1};
    tbl[6]  = '{22, 1,0,0, 12'd2, 0,0,1};
    tbl[7]  = '{29, 1,0,0, 12'd2, 0,0,1};
    tbl[8]  = '{30, 0,0,1, 12'd2, 0,1,1};
    tbl[9]  = '{34, 0,0,1, 12'd2, 0,0,1};
    tbl[10] = '{35, 0,0,0, 12'd0, 0,0,0};
    tbl[11] = '{36, 0,0,0, 12'd0, 0,0,0};
    ti = 0;
    for (int c = 0; c <= 36; c++) begin
      cycle(c == 0, 0, 0, 0);
      if (ti < 12 && tbl[ti].cyc == c) begin
        check("tbl_enb",  32'(bus_if.pix_enb),     32'(tbl[ti].enb));
        check("tbl_hb",   32'(bus_if.hblank),      32'(tbl[ti].hb));
        check("tbl_vb",   32'(bus_if.vblank),      32'(tbl[ti].vb));
        check("tbl_line", 32'(bus_if.line_idx),    32'(tbl[ti].line));
        check("tbl_fs",   32'(bus_if.frame_start), 32'(tbl[ti].fs));
        check("tbl_fd",   32'(bus_if.frame_done),  32'(tbl[ti].fd));
        check("tbl_busy", 32'(bus_if.busy),        32'(tbl[ti].busy));
        ti++;
      end
    end

    // Continuous frames with start held, then stop during line 1 of frame 2.
    fs_a = -1; fs_b = -1; n_fs = 0; max_line = 0;
    for (int c = 0; c <= 75; c++) begin
      cycle(c <= 70, c == 48, 0, 0);
      if (bus_if.frame_start) begin
        if (fs_a < 0) fs_a = c; else if (fs_b < 0) fs_b = c;
        if (c > 35) n_fs++;
      end
      if (c == 34) check("cont_vblank_end", 32'(bus_if.vblank), 32'd1);
      if (c == 35) check("cont_line_restart", 32'(bus_if.line_idx), 32'd0);
      if (c > 35 && c < 70 && int'(bus_if.line_idx) > max_line) max_line = int'(bus_if.line_idx);
      if (c == 70) check("stop_idle", 32'(bus_if.busy), 32'd0);
    end
    check("cont_fs_gap", 32'(fs_b - fs_a), 32'd35);
    check("stop_no_refs", 32'(n_fs), 32'd0);
    check("stop_full_frame", 32'(max_line), 32'd2);

    // Mode freeze: test=1 at start, dropped mid-frame.
    fd_a = -1; fd_b = -1;
    for (int c = 0; c <= 62; c++) begin
      cycle(c < 40, 0, c < 5, 0);
      if (bus_if.frame_done) begin
        if (fd_a < 0) fd_a = c; else if (fd_b < 0) fd_b = c;
      end
      if (c == 10) check("freeze_pix_test", 32'(bus_if.pix_test), 32'd1);
      if (c == 30) check("next_pix_test", 32'(bus_if.pix_test), 32'd0);
    end
    check("test_frame_len", 32'(fd_a), 32'd19);
    check("normal_frame_len", 32'(fd_b), 32'd54);

    // start and stop together in IDLE, as a pulse.
    for (int c = 0; c <= 37; c++) cycle(c == 0, c == 0, 0, 0);
    check("startstop_idle", 32'(bus_if.busy), 32'd0);

    // Reset in the middle of HBLANK.
    for (int c = 0; c <= 9; c++) cycle(c == 0, 0, 0, 0);
    check("pre_reset_hblank", 32'(bus_if.hblank), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_hblank",  32'(bus_if.hblank),   32'd0);
    check("rst_pix_enb", 32'(bus_if.pix_enb),  32'd0);
    check("rst_busy",    32'(bus_if.busy),     32'd0);
    check("rst_line",    32'(bus_if.line_idx), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Clean frame after reset, with spurious end_line outside ACTIVE.
    cycle(1, 0, 0, 0);
    check("post_rst_fs", 32'(bus_if.frame_start), 32'd1);
    for (int c = 1; c <= 40; c++) cycle(0, 0, 0, !model_active());

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      s   = ($urandom_range(0, 3) != 0);
      inj = !model_active() && ($urandom_range(0, 2) == 0);
      cycle(s, $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), inj);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_frame_ctrl.md
Name: pattern_frame_ctrl

Overview:
Frame sequencer for the pattern generator. It drives the enable and mode of the 12-bit pixel/line counter, consumes that counter's end_line flag, and counts lines within a frame. It inserts horizontal and vertical blanking and issues frame_start/frame_done strobes to the pattern datapath. It sits between the top-level control interface (start/stop/test) and the pixel counter.

Parameters:
LINES_NORMAL, 720, active lines per frame in normal mode (1..4096)
LINES_TEST, 16, active lines per frame in test mode (1..4096)
HBLANK_CYC, 32, blanking cycles between lines (1..4095)
VBLANK_CYC, 256, blanking cycles after the last line of a frame (1..4095)

Ports:
clk  in  1  16 ns master clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level/pulse; begins frame sequencing when sampled high in IDLE
stop  in  1  pulse; request to halt at the next frame boundary
test  in  1  mode request: 1 = test, 0 = normal; sampled only at frame start
end_line  in  1  pixel counter terminal-count flag (combinational from the counter)
pix_enb  out  1  enable to the pixel counter (low clears the counter)
pix_test  out  1  mode to the pixel counter, frozen for the whole frame
line_idx  out  12  current active line index, 0-based
hblank  out  1  high in HBLANK
vblank  out  1  high in VBLANK
frame_start  out  1  one-cycle strobe in the first ACTIVE cycle of each frame
frame_done  out  1  one-cycle strobe in the first VBLANK cycle
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is clk/rst_n, asynchronous, active-low. On reset: state = IDLE; all outputs 0; line_idx = 0; blank counter = 0; stop_pend = 0.
- Outputs are Moore-decoded from registered state/flags. No combinational path exists from inputs to outputs.
- FSM states:
  - IDLE.
    - start=1 -> ACTIVE.
    - At the same edge: pix_test <= test, line_idx <= 0, stop_pend <= 0.
  - ACTIVE: pix_enb=1.
    - end_line=1 and line_idx == last -> VBLANK.
    - end_line=1 otherwise -> HBLANK.
    - last = (pix_test ? LINES_TEST : LINES_NORMAL) - 1.
  - HBLANK: pix_enb=0; hblank=1.
    - Blank counter counts 0..HBLANK_CYC-1.
    - At terminal value: line_idx += 1, -> ACTIVE.
  - VBLANK: pix_enb=0; vblank=1.
    - Blank counter counts 0..VBLANK_CYC-1.
    - At terminal value with stop_pend=1 or start=0 -> IDLE; line_idx <= 0.
    - At terminal value otherwise -> ACTIVE; line_idx <= 0; pix_test <= test (re-sampled).
- Blank counter: 12 bits; cleared on every state entry.
- Latency:
  - pix_enb rises 1 cycle after start is sampled.
  - Leaving ACTIVE takes 1 cycle after end_line is sampled. The counter sees enb=1 on that edge and enb=0 on the next edge, so it clears before the next line.
  - Each line costs HBLANK_CYC cycles of blanking.
- frame_start is high in the first ACTIVE cycle of each frame (line_idx=0). frame_done is high in the first VBLANK cycle.
- stop:
  - Sampled in any non-IDLE state and sets stop_pend.
  - Honoured only at VBLANK end; a frame is never truncated.
  - stop in IDLE is ignored.
- end_line outside ACTIVE is ignored.
- A change of test mid-frame has no effect until the next frame start.
- start=1 and stop=1 together in IDLE: the machine starts, then stops after one frame.
- Reset asserted mid-frame returns everything to reset values immediately, with pix_enb=0.
- line_idx never exceeds last; it does not wrap within a frame.

Optional Feature:
PATTERN_FRAME_CNT_EN
- Defined: adds output frame_cnt [15:0].
  - Reset 0.
  - Increments on the cycle frame_done is high; wraps from 0xFFFF to 0.
  - Cleared when leaving IDLE via start.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, ACTIVE=2'd1, HBLANK=2'd2, VBLANK=2'd3), the 12-bit counter width constant, and default line/blank counts.
- One sub-module is natural: pattern_blank_timer, a 12-bit down-counter with load and a done flag, shared by HBLANK and VBLANK.
- The FSM and line index stay in the top module.

Test Plan:
- Bench setup: LINES_NORMAL=3, LINES_TEST=2, HBLANK_CYC=3, VBLANK_CYC=5, and a behavioural pixel counter raising end_line after 8 enabled cycles.
- Single frame: start pulse with test=0, then start=0 -> frame_start at cycle 1; line_idx 0,1,2; hblank 3 cycles between lines; frame_done once; vblank 5 cycles; then IDLE with busy=0.
- Continuous: start held at 1 -> frame N+1 frame_start occurs exactly 1 cycle after vblank ends; line_idx restarts at 0; no gap cycles.
- Mode freeze: test=1 at start, toggle test to 0 mid-frame -> pix_test stays 1, frame has exactly 2 lines; next frame uses 3 lines.
- Stop mid-line: stop pulse during line 1, start held -> lines 1 and 2 complete, VBLANK completes, then IDLE; no second frame_start.
- Reset mid-HBLANK: assert rst_n=0 for 2 cycles -> all outputs 0 asynchronously, line_idx=0; a later start begins a clean frame. Also inject a spurious end_line in HBLANK/VBLANK -> no state change.
